// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Registers the winning operation onto the ALU inputs and returns the result over a valid/ready channel.
module alu_arbiter #(
  parameter int WIDTH    = 32,
  parameter int LONG_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [2:0]       req0_funct3,
  input  logic             req0_type,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [2:0]       req1_funct3,
  input  logic             req1_type,
  output logic [WIDTH-1:0] alu_operand1,
  output logic [WIDTH-1:0] alu_operand2,
  output logic [2:0]       alu_funct3,
  output logic             alu_type,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Requesters hold valid and payload stable until ready; ready never rises without valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LONG_CNT  = 4'(LONG_LAT - 1);
  localparam logic [2:0] F3_MULDIV = 3'b011;

  state_t           state;
  state_t           state_next;
  logic             ptr;
  logic [3:0]       cnt;
  logic             sel1;
  logic             accept;
  logic [WIDTH-1:0] sel_op1;
  logic [WIDTH-1:0] sel_op2;
  logic [2:0]       sel_funct3;
  logic             sel_type;

  // Requester 1 wins when it is alone, or when both are valid and the pointer favours it.
  assign sel1       = req1_valid & (~req0_valid | ptr);
  assign req0_ready = (state == IDLE) & ~rst & req0_valid & ~sel1;
  assign req1_ready = (state == IDLE) & ~rst & sel1;
  assign accept     = req0_ready | req1_ready;

  assign sel_op1    = sel1 ? req1_op1    : req0_op1;
  assign sel_op2    = sel1 ? req1_op2    : req0_op2;
  assign sel_funct3 = sel1 ? req1_funct3 : req0_funct3;
  assign sel_type   = sel1 ? req1_type   : req0_type;

  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_funct3   <= '0;
      alu_type     <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      cnt          <= '0;
      ptr          <= 1'b0;
    end else begin
      if (accept) begin
        alu_operand1 <= sel_op1;
        alu_operand2 <= sel_op2;
        alu_funct3   <= sel_funct3;
        alu_type     <= sel_type;
        rsp_id       <= sel1;
        cnt          <= (sel_funct3 == F3_MULDIV) ? LONG_CNT : 4'd0;
      end
      // The ALU inputs are frozen during EXEC, so its output is settled when cnt runs out.
      if (state == EXEC) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else             rsp_result <= alu_result;
      end
      if (state == RESP && rsp_ready) ptr <= ~rsp_id;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stand-in, cycle-level reference model,
// table-driven vectors, hand-written corner sequences and randomized traffic.
module tb_alu_arbiter;
  localparam int W        = 32;
  localparam int LONG_LAT = 4;

  typedef struct {
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [2:0]   f3;
    logic         ty;
  } op_t;

  typedef struct {
    logic         id;
    op_t          op;
    logic [W-1:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic [2:0]   req0_funct3 = '0, req1_funct3 = '0;
  logic         req0_type = 1'b0, req1_type = 1'b0;
  logic [W-1:0] alu_operand1, alu_operand2, alu_result, rsp_result;
  logic [2:0]   alu_funct3;
  logic         alu_type, rsp_valid, rsp_id, busy;
  logic         rsp_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  op_t          q0[$];
  op_t          q1[$];
  logic [W-1:0] exp_q[$];
  logic         dut_id_log[$];
  logic [W-1:0] dut_res_log[$];
  logic         hs0 = 1'b0, hs1 = 1'b0;

  // Reference model state: expressed as "operation in flight" and "cycles left until the response".
  logic         m_inflight = 1'b0;
  int           m_wait = 0;
  logic         m_ptr = 1'b0;
  logic         m_rsp_id = 1'b0;
  logic [W-1:0] m_rsp_res = '0;
  logic [W-1:0] m_pend_res = '0;
  op_t          m_op;

  alu_arbiter #(.WIDTH(W), .LONG_LAT(LONG_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req0_funct3(req0_funct3), .req0_type(req0_type),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req1_funct3(req1_funct3), .req1_type(req1_type),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_funct3(alu_funct3),
    .alu_type(alu_type), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .busy(busy)
  );

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] f3, input logic ty);
    case (f3)
      3'b000:  return ty ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return ty ? a * b : ((b == 0) ? '1 : a / b);
      3'b100:  return a ^ b;
      3'b101:  return ty ? W'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_operand1, alu_operand2, alu_funct3, alu_type);

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + reference model + scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    logic win;
    if (rst) begin
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_alu_op1", alu_operand1, 0);
      m_inflight = 1'b0; m_wait = 0; m_ptr = 1'b0; m_rsp_id = 1'b0;
      m_rsp_res = '0; m_pend_res = '0;
      m_op.op1 = '0; m_op.op2 = '0; m_op.f3 = '0; m_op.ty = 1'b0;
      hs0 = 1'b0; hs1 = 1'b0;
      exp_q.delete();
    end else begin
      check("req0_ready", req0_ready, !m_inflight && req0_valid && (!req1_valid || !m_ptr));
      check("req1_ready", req1_ready, !m_inflight && req1_valid && (!req0_valid || m_ptr));
      check("busy", busy, m_inflight);
      check("rsp_valid", rsp_valid, m_inflight && m_wait == 0);
      check("rsp_id", rsp_id, m_rsp_id);
      check("rsp_result", rsp_result, m_rsp_res);
      check("alu_operand1", alu_operand1, m_op.op1);
      check("alu_operand2", alu_operand2, m_op.op2);
      check("alu_funct3", alu_funct3, m_op.f3);
      check("alu_type", alu_type, m_op.ty);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      if (rsp_valid && rsp_ready) begin
        dut_id_log.push_back(rsp_id);
        dut_res_log.push_back(rsp_result);
        if (exp_q.size() == 0) check("sb_unexpected_rsp", 1, 0);
        else check("sb_result", rsp_result, exp_q.pop_front());
      end
      if (!m_inflight) begin
        if (req0_valid || req1_valid) begin
          win = req1_valid && (!req0_valid || m_ptr);
          m_op.op1 = win ? req1_op1 : req0_op1;
          m_op.op2 = win ? req1_op2 : req0_op2;
          m_op.f3  = win ? req1_funct3 : req0_funct3;
          m_op.ty  = win ? req1_type : req0_type;
          m_inflight = 1'b1;
          m_wait     = (m_op.f3 == 3'b011) ? LONG_LAT : 1;
          m_rsp_id   = win;
          m_pend_res = alu_ref(m_op.op1, m_op.op2, m_op.f3, m_op.ty);
          exp_q.push_back(m_pend_res);
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_rsp_res = m_pend_res;
      end else if (rsp_ready) begin
        m_inflight = 1'b0;
        m_ptr = !m_rsp_id;
      end
    end
  end

  task automatic apply_inputs();
    req0_valid = (q0.size() > 0);
    if (q0.size() > 0) begin
      req0_op1 = q0[0].op1; req0_op2 = q0[0].op2; req0_funct3 = q0[0].f3; req0_type = q0[0].ty;
    end
    req1_valid = (q1.size() > 0);
    if (q1.size() > 0) begin
      req1_op1 = q1[0].op1; req1_op2 = q1[0].op2; req1_funct3 = q1[0].f3; req1_type = q1[0].ty;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (hs0 && q0.size() > 0) void'(q0.pop_front());
    if (hs1 && q1.size() > 0) void'(q1.pop_front());
    apply_inputs();
  endtask

  task automatic push_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] f3, input logic ty);
    op_t o;
    o.op1 = a; o.op2 = b; o.f3 = f3; o.ty = ty;
    if (id) q1.push_back(o);
    else    q0.push_back(o);
  endtask

  task automatic run_until_logged(input int n, input string name);
    int start;
    start = dut_id_log.size();
    for (int i = 0; i < 100 && dut_id_log.size() < start + n; i++) step();
    check({"timeout_", name}, dut_id_log.size() >= start + n, 1);
  endtask

  function automatic vec_t mk_vec(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] f3, input logic ty, input logic [W-1:0] exp);
    vec_t v;
    v.id = id; v.op.op1 = a; v.op.op2 = b; v.op.f3 = f3; v.op.ty = ty; v.exp = exp;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   base;
    vecs[0] = mk_vec(1'b0, 32'd5,         32'd3,         3'b000, 1'b0, 32'd8);
    vecs[1] = mk_vec(1'b0, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 3'b000, 1'b1, 32'd0);
    vecs[2] = mk_vec(1'b1, 32'h3FFF_FFFF, 32'd3,         3'b011, 1'b1, 32'hBFFF_FFFD);
    vecs[3] = mk_vec(1'b1, 32'd100,       32'd7,         3'b011, 1'b0, 32'd14);
    vecs[4] = mk_vec(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100, 1'b0, 32'hFF00_FF00);
    vecs[5] = mk_vec(1'b1, 32'd0,         32'd1,         3'b000, 1'b1, 32'hFFFF_FFFF);
    vecs[6] = mk_vec(1'b0, 32'hFFFF_0000, 32'h1234_5678, 3'b111, 1'b0, 32'h1234_0000);

    // Both requesters valid straight out of reset: strict alternation expected.
    rsp_ready = 1'b1;
    push_op(1'b0, 32'd1, 32'd2, 3'b000, 1'b0);
    push_op(1'b0, 32'd3, 32'd4, 3'b000, 1'b0);
    push_op(1'b1, 32'd10, 32'd20, 3'b000, 1'b0);
    push_op(1'b1, 32'd30, 32'd40, 3'b000, 1'b0);
    apply_inputs();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    run_until_logged(4, "fairness");
    base = dut_id_log.size() - 4;
    for (int i = 0; i < 4; i++)
      check($sformatf("fair_order%0d", i), dut_id_log[base + i], (i % 2 == 1));

    // Table-driven single operations.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].id) q1.push_back(vecs[i].op);
      else            q0.push_back(vecs[i].op);
      run_until_logged(1, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_result", i), dut_res_log[dut_res_log.size() - 1], vecs[i].exp);
      check($sformatf("vec%0d_id", i), dut_id_log[dut_id_log.size() - 1], vecs[i].id);
    end

    // Response backpressure with req0 waiting.
    rsp_ready = 1'b0;
    push_op(1'b1, 32'd6, 32'd7, 3'b011, 1'b1);
    for (int i = 0; i < 20 && !rsp_valid; i++) step();
    check("bp_reached_resp", rsp_valid, 1);
    push_op(1'b0, 32'd11, 32'd22, 3'b000, 1'b0);
    repeat (5) step();
    check("bp_held_result", rsp_result, 32'd42);
    rsp_ready = 1'b1;
    run_until_logged(2, "backpressure");
    check("bp_second_id", dut_id_log[dut_id_log.size() - 1], 0);
    check("bp_second_result", dut_res_log[dut_res_log.size() - 1], 32'd33);

    // Request withdrawn while req0 is in flight.
    rsp_ready = 1'b0;
    push_op(1'b0, 32'd7, 32'd9, 3'b000, 1'b0);
    repeat (3) step();
    push_op(1'b1, 32'd99, 32'd1, 3'b000, 1'b0);
    step();
    q1.delete();
    step();
    rsp_ready = 1'b1;
    run_until_logged(1, "withdraw");
    base = dut_id_log.size();
    repeat (6) step();
    check("wd_no_extra_rsp", dut_id_log.size(), base);
    check("wd_last_id", dut_id_log[base - 1], 0);

    // Reset during EXEC of a DIV; pointer must come back to requester 0.
    push_op(1'b0, 32'd1000, 32'd10, 3'b011, 1'b0);
    for (int i = 0; i < 10 && !busy; i++) step();
    step();
    check("mid_busy_before_rst", busy, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    q0.delete(); q1.delete();
    apply_inputs();
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_alu_op1", alu_operand1, 0);
    check("mid_rst_alu_funct3", alu_funct3, 0);
    check("mid_rst_rsp_result", rsp_result, 0);
    check("mid_rst_rsp_id", rsp_id, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    base = dut_id_log.size();
    repeat (6) step();
    check("mid_no_rsp_after_rst", dut_id_log.size(), base);
    push_op(1'b0, 32'd2, 32'd2, 3'b000, 1'b0);
    push_op(1'b1, 32'd3, 32'd3, 3'b000, 1'b0);
    step();
    run_until_logged(2, "post_reset");
    check("post_rst_first_id", dut_id_log[base], 0);
    check("post_rst_second_id", dut_id_log[base + 1], 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      op_t o;
      o.op1 = $urandom;
      o.op2 = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 40));
      o.f3  = 3'($urandom_range(0, 7));
      o.ty  = 1'($urandom_range(0, 1));
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(o);
      else if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(o);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 300 && (q0.size() > 0 || q1.size() > 0 || m_inflight); i++) step();
    check("drain_done", (q0.size() > 0 || q1.size() > 0 || m_inflight), 0);
    repeat (2) step();
    check("sb_exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
